video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator that succeeds the fixed 640x480 timing block. It sits in the `pixel_clk` domain and drives the HDMI encoder and the sprite/tile renderers. It generalises resolution, porches, sync polarity and counter width. It adds line/frame start strobes, a frame counter, and registered flags aligned exactly to `pixel_x`/`pixel_y`.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch.
- `H_SYNC`, default 96: horizontal sync width.
- `H_BP`, default 48: horizontal back porch.
- `V_ACTIVE`, default 480: visible lines.
- `V_FP`, default 10: vertical front porch.
- `V_SYNC`, default 2: vertical sync width.
- `V_BP`, default 33: vertical back porch.
- `HS_POL`, default 0: asserted level of `hsync`; 0 means active-low.
- `VS_POL`, default 0: asserted level of `vsync`.
- `CW`, default 10: width of the position counters.
- `FCW`, default 16: width of the frame counter.

Ports:
- `pixel_clk` input 1: pixel clock. Single clock domain.
- `reset` input 1: synchronous, active-high.
- `vtg_ce` input 1: pixel advance enable.
- `pixel_x` output CW: current horizontal position.
- `pixel_y` output CW: current vertical position.
- `hsync` output 1: horizontal sync, driven at `HS_POL` polarity.
- `vsync` output 1: vertical sync, driven at `VS_POL` polarity.
- `hblank` output 1: high when `pixel_x >= H_ACTIVE`.
- `vblank` output 1: high when `pixel_y >= V_ACTIVE`.
- `video_on` output 1: high when both `hblank` and `vblank` are low.
- `line_start` output 1: one-pixel strobe at `pixel_x == 0`.
- `frame_start` output 1: one-pixel strobe at position (0,0).
- `frame_count` output FCW: count of completed frames, wrapping.

## Operation
- Totals are derived: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`; `V_TOTAL` is formed the same way.
- Line order on each axis: active, then front porch, then sync, then back porch. Position 0 is the first visible pixel.
- Horizontal counter:
  - Advances only in cycles with `vtg_ce=1`.
  - At `H_TOTAL-1` it wraps to 0.
- Vertical counter:
  - Advances only on a horizontal wrap.
  - At `V_TOTAL-1` it wraps to 0.
- `frame_count` increments on the wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is modulo 2^FCW with no saturation.
- `hsync` is asserted for `H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC`. `vsync` uses the same rule with the V parameters.
- `hsync`, `vsync`, `hblank`, `vblank` and `video_on` are registers. They are computed from the next counter values, so they always describe the `pixel_x`/`pixel_y` presented in the same cycle. Outputs never lag the position.
- `line_start = (pixel_x==0) & vtg_ce`. It is high in exactly one `vtg_ce` cycle per line.
- `frame_start = (pixel_x==0) & (pixel_y==0) & vtg_ce`.
- With `vtg_ce=0`, every registered output holds and both strobes are 0.
- Reset values: `pixel_x=0`, `pixel_y=0`, `frame_count=0`, `hsync=~HS_POL`, `vsync=~VS_POL`, `hblank=0`, `vblank=0`, `video_on=1`. Strobes are 0 while reset is high.
- Reset asserted mid-frame: on the next edge all state returns to the reset values, regardless of `vtg_ce`. Reset has priority over `vtg_ce`.
- First cycle after reset release with `vtg_ce=1`: `frame_start=1`, and (0,0) is the pixel consumed.
- Elaboration checks:
  - All porch and sync parameters must be at least 1.
  - `H_TOTAL-1` and `V_TOTAL-1` must fit in CW bits.
  - `$fatal` fires otherwise.

## Timing
- Position update latency is one `pixel_clk` edge per `vtg_ce` cycle.
- The flags have zero offset relative to the position.
- Strobes are combinational from registers AND `vtg_ce`. This is one AND level only, for the renderers' same-cycle capture.
- Default frame is 800x525 positions, which is 420000 `vtg_ce` cycles per `frame_count` increment.
- Throughput is one pixel per `vtg_ce`. `vtg_ce` may be held constantly high.

## Structure
- Package `starsoc_params` gains:
  - a `video_timing_t` struct with fields active, fp, sync, bp and pol;
  - a constant `VT_640X480_60` holding the defaults.
- The top level may take these values from the package.
- Sub-module `timing_axis_counter`, instantiated twice (H and V). It provides:
  - parameters LEN_ACTIVE, FP, SYNC, BP, POL, CW;
  - inputs `inc` and `reset`;
  - outputs `count`, `wrap`, `sync`, `blank`;
  - its own next-value flag decode.
- The V instance's `inc` is the H instance's `wrap`.

## Test plan
- Reset, then `vtg_ce=1` for 2 frames:
  - `frame_start` pulses at cycles 0 and 420000;
  - `frame_count` reads 1 then 2;
  - `line_start` pulses every 800 cycles.
- Horizontal sync window:
  - at `pixel_x=655` `hsync=1`;
  - `hsync=0` for `pixel_x` 656..751;
  - at 752 `hsync=1`;
  - `hblank` rises exactly at 640 in the same cycle.
- Vertical sync window:
  - `vsync` is low only for `pixel_y` 490..491;
  - `vblank` is high for `pixel_y` 480..524;
  - the counter wraps from (799,524) to (0,0).
- `vtg_ce` toggled 1/0 each cycle:
  - positions advance every other cycle;
  - strobes are never high in a `vtg_ce=0` cycle;
  - flags hold.
- Reset asserted at (300,200) with `vtg_ce=1`:
  - the next cycle shows (0,0), `video_on=1`, `frame_count=0`.
- Alternate parameter set 1280x720 (110/40/220, 5/5/20), `HS_POL=VS_POL=1`, `CW=11`:
  - `hsync` is high for `pixel_x` 1390..1429;
  - a frame is 1650x750 positions.
- `FCW=2`: after 4 frames `frame_count` wraps 3 to 0.

Source files
------------

// File: rtl/starsoc_params.sv
// SoC-wide parameter package: video timing descriptors shared by display blocks.
//   video_timing_t : one axis of a raster (active, front porch, sync, back porch, sync polarity)
//   video_mode_t   : horizontal + vertical axis pair
//   VT_640X480_60  : 640x480@60 timing (800x525 total, active-low syncs)
package starsoc_params;

    localparam int unsigned VT_FIELD_W = 16;

    typedef struct packed {
        logic [VT_FIELD_W-1:0] active;
        logic [VT_FIELD_W-1:0] fp;
        logic [VT_FIELD_W-1:0] sync;
        logic [VT_FIELD_W-1:0] bp;
        logic                  pol;
    } video_timing_t;

    typedef struct packed {
        video_timing_t h;
        video_timing_t v;
    } video_mode_t;

    localparam video_mode_t VT_640X480_60 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48, pol: 1'b0},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33, pol: 1'b0}
    };

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: position counter with wrap plus registered sync/blank flags.
// Flags are decoded from the next count so they always match the presented count.
//   pixel_clk    : clock
//   reset        : synchronous active-high reset
//   inc          : advance the position by one
//   count        : current position (0 = first active position)
//   wrap         : combinational, high in the inc cycle that takes count from last to 0
//   sync         : sync output at POL polarity
//   blank        : high when count >= LEN_ACTIVE
//   blank_next_c : combinational blank value for the next cycle
module timing_axis_counter #(
    parameter int unsigned LEN_ACTIVE = 640,
    parameter int unsigned FP         = 16,
    parameter int unsigned SYNC       = 96,
    parameter int unsigned BP         = 48,
    parameter bit          POL        = 1'b0,
    parameter int unsigned CW         = 10
) (
    input  logic          pixel_clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          sync,
    output logic          blank,
    output logic          blank_next_c
);

    localparam int unsigned TOTAL      = LEN_ACTIVE + FP + SYNC + BP;
    localparam int unsigned SYNC_START = LEN_ACTIVE + FP;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;

    if (FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_porch
        $fatal(1, "timing_axis_counter: porch and sync widths must be at least 1");
    end
    if (((TOTAL - 1) >> CW) != 0) begin : g_bad_width
        $fatal(1, "timing_axis_counter: total-1 does not fit in CW bits");
    end

    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END   = CW'(LEN_ACTIVE);
    localparam logic [CW-1:0] SYNC_BEG  = CW'(SYNC_START);
    localparam logic [CW-1:0] SYNC_STOP = CW'(SYNC_END);

    logic [CW-1:0] count_next;
    logic          sync_next;

    // Next position and the flags that will describe it
    always_comb begin
        count_next = count;
        wrap       = inc && (count == LAST);
        if (inc) begin
            count_next = (count == LAST) ? '0 : count + CW'(1);
        end
        sync_next    = ((count_next >= SYNC_BEG) && (count_next < SYNC_STOP)) ? POL : ~POL;
        blank_next_c = (count_next >= ACT_END);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            count <= '0;
            sync  <= ~POL;
            blank <= 1'b0;
        end else if (inc) begin
            count <= count_next;
            sync  <= sync_next;
            blank <= blank_next_c;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator (pixel_clk domain).
//   pixel_clk   : pixel clock
//   reset       : synchronous active-high reset
//   vtg_ce      : pixel advance enable
//   pixel_x/y   : current position, (0,0) is the first visible pixel
//   hsync/vsync : syncs at HS_POL/VS_POL polarity, aligned to pixel_x/pixel_y
//   hblank/vblank/video_on : registered blanking flags aligned to the position
//   line_start  : strobe when pixel_x==0 and vtg_ce
//   frame_start : strobe when position is (0,0) and vtg_ce
//   frame_count : completed frames, modulo 2^FCW
module video_timing_gen
    import starsoc_params::*;
#(
    parameter int unsigned H_ACTIVE = 32'(VT_640X480_60.h.active),
    parameter int unsigned H_FP     = 32'(VT_640X480_60.h.fp),
    parameter int unsigned H_SYNC   = 32'(VT_640X480_60.h.sync),
    parameter int unsigned H_BP     = 32'(VT_640X480_60.h.bp),
    parameter int unsigned V_ACTIVE = 32'(VT_640X480_60.v.active),
    parameter int unsigned V_FP     = 32'(VT_640X480_60.v.fp),
    parameter int unsigned V_SYNC   = 32'(VT_640X480_60.v.sync),
    parameter int unsigned V_BP     = 32'(VT_640X480_60.v.bp),
    parameter bit          HS_POL   = VT_640X480_60.h.pol,
    parameter bit          VS_POL   = VT_640X480_60.v.pol,
    parameter int unsigned CW       = 10,
    parameter int unsigned FCW      = 16
) (
    input  logic           pixel_clk,
    input  logic           reset,
    input  logic           vtg_ce,
    output logic [CW-1:0]  pixel_x,
    output logic [CW-1:0]  pixel_y,
    output logic           hsync,
    output logic           vsync,
    output logic           hblank,
    output logic           vblank,
    output logic           video_on,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    logic h_wrap;
    logic v_wrap;
    logic h_blank_next;
    logic v_blank_next;
    logic x_zero;
    logic frame_zero;

    timing_axis_counter #(
        .LEN_ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
    ) u_h (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .inc         (vtg_ce),
        .count       (pixel_x),
        .wrap        (h_wrap),
        .sync        (hsync),
        .blank       (hblank),
        .blank_next_c(h_blank_next)
    );

    timing_axis_counter #(
        .LEN_ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
    ) u_v (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .inc         (h_wrap),
        .count       (pixel_y),
        .wrap        (v_wrap),
        .sync        (vsync),
        .blank       (vblank),
        .blank_next_c(v_blank_next)
    );

    // x_zero/frame_zero are registered position decodes so the strobes are a single gate
    // from vtg_ce; a V wrap is the only way to land on (0,0).
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            frame_count <= '0;
            video_on    <= 1'b1;
            x_zero      <= 1'b1;
            frame_zero  <= 1'b1;
        end else if (vtg_ce) begin
            frame_count <= frame_count + FCW'(v_wrap);
            video_on    <= ~h_blank_next & ~v_blank_next;
            x_zero      <= h_wrap;
            frame_zero  <= v_wrap;
        end
    end

    assign line_start  = x_zero & vtg_ce & ~reset;
    assign frame_start = frame_zero & vtg_ce & ~reset;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: three instances (small active-low, small
// active-high at the CW boundary, and the 640x480 defaults) share reset/vtg_ce and are
// compared against an arithmetic model driven by the count of consumed pixels.
module tb_video_timing_gen;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] fc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        von;
        logic        ls;
        logic        fs;
    } exp_t;

    localparam int EW = $bits(exp_t);

    logic pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic reset;
    logic vtg_ce;

    logic [5:0]  x0, y0;
    logic [1:0]  fc0;
    logic        hs0, vs0, hb0, vb0, von0, ls0, fs0;
    logic [4:0]  x1, y1;
    logic [3:0]  fc1;
    logic        hs1, vs1, hb1, vb1, von1, ls1, fs1;
    logic [9:0]  x2, y2;
    logic [15:0] fc2;
    logic        hs2, vs2, hb2, vb2, von2, ls2, fs2;

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(6), .FCW(2)
    ) u0 (
        .pixel_clk(pixel_clk), .reset(reset), .vtg_ce(vtg_ce),
        .pixel_x(x0), .pixel_y(y0), .hsync(hs0), .vsync(vs0), .hblank(hb0), .vblank(vb0),
        .video_on(von0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
    );

    video_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(5), .FCW(4)
    ) u1 (
        .pixel_clk(pixel_clk), .reset(reset), .vtg_ce(vtg_ce),
        .pixel_x(x1), .pixel_y(y1), .hsync(hs1), .vsync(vs1), .hblank(hb1), .vblank(vb1),
        .video_on(von1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
    );

    video_timing_gen u2 (
        .pixel_clk(pixel_clk), .reset(reset), .vtg_ce(vtg_ce),
        .pixel_x(x2), .pixel_y(y2), .hsync(hs2), .vsync(vs2), .hblank(hb2), .vblank(vb2),
        .video_on(von2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
    );

    exp_t obs0, obs1, obs2;
    logic [3*EW-1:0] obs_all;
    assign obs0    = {32'(x0), 32'(y0), 32'(fc0), hs0, vs0, hb0, vb0, von0, ls0, fs0};
    assign obs1    = {32'(x1), 32'(y1), 32'(fc1), hs1, vs1, hb1, vb1, von1, ls1, fs1};
    assign obs2    = {32'(x2), 32'(y2), 32'(fc2), hs2, vs2, hb2, vb2, von2, ls2, fs2};
    assign obs_all = {obs0, obs1, obs2};

    int compared   = 0;
    int mismatched = 0;
    longint unsigned n = 0;   // pixels consumed since reset

    // Expected outputs after cnt pixels, derived from the raster rules
    function automatic exp_t model(longint unsigned cnt,
                                   longint unsigned ha, longint unsigned hf,
                                   longint unsigned hs, longint unsigned hb,
                                   longint unsigned va, longint unsigned vf,
                                   longint unsigned vs, longint unsigned vb,
                                   bit ph, bit pv, longint unsigned fcw, bit ce, bit rst);
        exp_t e;
        longint unsigned ht, vt, x, y, f;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        x  = cnt % ht;
        y  = (cnt / ht) % vt;
        f  = (cnt / (ht * vt)) % (64'd1 << fcw);
        e.x   = 32'(x);
        e.y   = 32'(y);
        e.fc  = 32'(f);
        e.hs  = (x >= ha + hf && x < ha + hf + hs) ? ph : !ph;
        e.vs  = (y >= va + vf && y < va + vf + vs) ? pv : !pv;
        e.hb  = (x >= ha);
        e.vb  = (y >= va);
        e.von = !e.hb && !e.vb;
        e.ls  = ce && !rst && (x == 0);
        e.fs  = e.ls && (y == 0);
        return e;
    endfunction

    function automatic logic [3*EW-1:0] expect_all(bit ce, bit rst);
        return {model(n, 16, 2, 3, 4, 10, 1, 2, 2, 1'b0, 1'b0, 2, ce, rst),
                model(n, 20, 3, 4, 5, 6, 2, 1, 3, 1'b1, 1'b1, 4, ce, rst),
                model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16, ce, rst)};
    endfunction

    task automatic apply(input bit rst, input bit ce);
        @(negedge pixel_clk);
        reset  = rst;
        vtg_ce = ce;
        #1;
    endtask

    task automatic advance();
        @(posedge pixel_clk);
        if (reset) n = 0;
        else if (vtg_ce) n++;
    endtask

    task automatic test_reset();
        logic [3*EW-1:0] e;
        reset  = 1'b1;
        vtg_ce = 1'b0;
        repeat (2) @(posedge pixel_clk);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, i[0]);
            e = expect_all(vtg_ce, reset);
            compared++;
            if (obs_all !== e) begin
                mismatched++;
                $display("FAIL reset_model: got %h want %h", obs_all, e);
            end
            compared++;
            if ({x2, y2, fc2, von2, hs2, vs2, hb2, hs1, vs1, ls2, fs2} !== {20'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                mismatched++;
                $display("FAIL reset_values: x=%0d y=%0d fc=%0d von=%b hs2=%b vs2=%b hb=%b hs1=%b vs1=%b ls=%b fs=%b",
                         x2, y2, fc2, von2, hs2, vs2, hb2, hs1, vs1, ls2, fs2);
            end
            advance();
        end
    endtask

    task automatic test_free_run();
        logic [3*EW-1:0] e;
        int fs_cnt = 0;
        int ls_cnt = 0;
        for (int i = 0; i < 1510; i++) begin
            apply(1'b0, 1'b1);
            e = expect_all(vtg_ce, reset);
            compared++;
            if (obs_all !== e) begin
                mismatched++;
                $display("FAIL free_run_model i=%0d: got %h want %h", i, obs_all, e);
            end
            if (fs0) begin
                fs_cnt++;
                compared++;
                if ((i % 375) != 0) begin
                    mismatched++;
                    $display("FAIL frame_start_pos: pulse at cycle %0d, want multiple of 375", i);
                end
            end
            if (ls0) ls_cnt++;
            if (y2 == 10'd0 && x2 >= 10'd639 && x2 <= 10'd752) begin
                compared++;
                if ({hs2, hb2} !== {!(x2 >= 10'd656 && x2 <= 10'd751), x2 >= 10'd640}) begin
                    mismatched++;
                    $display("FAIL default_hsync_window x=%0d: hs=%b hb=%b", x2, hs2, hb2);
                end
            end
            compared++;
            if (hs1 !== (x1 >= 5'd23 && x1 <= 5'd26)) begin
                mismatched++;
                $display("FAIL pos_hsync_window x=%0d: got %b", x1, hs1);
            end
            if (i == 374) begin
                compared++;
                if ({x0, y0, fc0} !== {6'd24, 6'd14, 2'd0}) begin
                    mismatched++;
                    $display("FAIL frame_last: got (%0d,%0d) fc=%0d want (24,14) fc=0", x0, y0, fc0);
                end
            end
            if (i == 375 || i == 750) begin
                compared++;
                if ({x0, y0, fc0} !== {6'd0, 6'd0, 2'(i / 375)}) begin
                    mismatched++;
                    $display("FAIL frame_wrap i=%0d: got (%0d,%0d) fc=%0d", i, x0, y0, fc0);
                end
            end
            if (i == 1499 || i == 1500) begin
                compared++;
                if (fc0 !== ((i == 1499) ? 2'd3 : 2'd0)) begin
                    mismatched++;
                    $display("FAIL fc_wrap i=%0d: got %0d", i, fc0);
                end
            end
            advance();
        end
        compared++;
        if (fs_cnt != 5 || ls_cnt != 61) begin
            mismatched++;
            $display("FAIL strobe_counts: frame_start %0d want 5, line_start %0d want 61", fs_cnt, ls_cnt);
        end
    endtask

    task automatic test_ce_toggle();
        logic [3*EW-1:0] e;
        apply(1'b1, 1'b0);
        advance();
        for (int i = 0; i < 200; i++) begin
            apply(1'b0, i[0] == 1'b0);
            e = expect_all(vtg_ce, reset);
            compared++;
            if (obs_all !== e) begin
                mismatched++;
                $display("FAIL ce_toggle_model i=%0d: got %h want %h", i, obs_all, e);
            end
            if (!vtg_ce) begin
                compared++;
                if ({ls0, fs0, ls1, fs1, ls2, fs2} !== 6'b0) begin
                    mismatched++;
                    $display("FAIL strobe_without_ce i=%0d: got %b", i, {ls0, fs0, ls1, fs1, ls2, fs2});
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic [3*EW-1:0] e;
        apply(1'b1, 1'b0);
        advance();
        for (int i = 0; i < 532; i++) begin
            apply(1'b0, 1'b1);
            e = expect_all(vtg_ce, reset);
            compared++;
            if (obs_all !== e) begin
                mismatched++;
                $display("FAIL pre_reset_model i=%0d: got %h want %h", i, obs_all, e);
            end
            advance();
        end
        apply(1'b1, 1'b1);
        compared++;
        if ({x0, y0, fc0, ls0, fs0} !== {6'd7, 6'd6, 2'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_frame_pos: got (%0d,%0d) fc=%0d ls=%b fs=%b want (7,6) fc=1 ls=0 fs=0",
                     x0, y0, fc0, ls0, fs0);
        end
        advance();
        apply(1'b0, 1'b0);
        compared++;
        if ({x0, y0, fc0, von0, x2, y2, von2} !== {6'd0, 6'd0, 2'd0, 1'b1, 10'd0, 10'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_mid: got u0 (%0d,%0d) fc=%0d von=%b u2 (%0d,%0d) von=%b",
                     x0, y0, fc0, von0, x2, y2, von2);
        end
        advance();
    endtask

    task automatic test_random();
        logic [3*EW-1:0] e;
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
            e = expect_all(vtg_ce, reset);
            compared++;
            if (obs_all !== e) begin
                mismatched++;
                $display("FAIL random_model i=%0d: got %h want %h", i, obs_all, e);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ce_toggle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
